// File: rtl/liic_pkg.sv
// Shared LIIC types for the link-layer transmit mux.
// Header word layout: {seq, channel}.
package liic_pkg;

  typedef enum logic [1:0] {
    LL_MUX_IDLE,
    LL_MUX_DATA,
    LL_MUX_DROP
  } liic_ll_mux_state_t;

  localparam logic LL_CH_HP = 1'b1;
  localparam logic LL_CH_LP = 1'b0;

  localparam int LL_HDR_MAX = 64;

  function automatic logic [LL_HDR_MAX-1:0] liic_ll_hdr(
    input logic                  ch,
    input logic [LL_HDR_MAX-2:0] seq
  );
    return {seq, ch};
  endfunction

endpackage

// File: rtl/liic_ll_tx_mux_if.sv
// Packet stream bundle: data, valid, sop, eop and ready.
// The master drives the payload; the slave returns ready.
interface liic_ll_tx_mux_if #(
  parameter int W = 8
) ();
  logic [W-1:0] dat;
  logic         val;
  logic         sop;
  logic         eop;
  logic         rdy;

  modport master (output dat, val, sop, eop, input rdy);
  modport slave  (input dat, val, sop, eop, output rdy);
endinterface

// File: rtl/liic_ll_tx_arb.sv
// Packet-boundary arbiter: HP priority with an LP starvation guard.
// run_q counts consecutive HP grants taken while LP was waiting.
module liic_ll_tx_arb
  import liic_pkg::*;
#(
  parameter int HP_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic linkup_i,
  input  logic hp_val_i,
  input  logic lp_val_i,
  input  logic gnt_en_i,
  output logic gnt_ch_o
);
  localparam int RW = $clog2(HP_BURST + 1);

  logic [RW-1:0] run_q;
  logic          lp_turn;

  assign lp_turn  = lp_val_i && (run_q == RW'(HP_BURST));
  assign gnt_ch_o = (hp_val_i && !lp_turn) ? LL_CH_HP : LL_CH_LP;

  // An HP grant with LP waiting can only happen below the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
    end else if (!linkup_i) begin
      run_q <= '0;
    end else if (gnt_en_i) begin
      if (gnt_ch_o == LL_CH_HP && lp_val_i)
        run_q <= run_q + RW'(1);
      else
        run_q <= '0;
    end
  end

endmodule

// File: rtl/liic_ll_tx_mux.sv
// LIIC link-layer TX mux: tags and merges HP/LP streams onto the link.
// Optional counters under LIIC_LL_TX_MUX_STATS_EN.
module liic_ll_tx_mux
  import liic_pkg::*;
#(
  parameter int ST_WIDTH = 8,
  parameter int HP_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ll_linkup,
  liic_ll_tx_mux_if.slave  hp_i,
  liic_ll_tx_mux_if.slave  lp_i,
  liic_ll_tx_mux_if.master ll_o
`ifdef LIIC_LL_TX_MUX_STATS_EN
  ,
  output logic [31:0] hp_pkt_cnt,
  output logic [31:0] lp_pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);
  liic_ll_mux_state_t state_q;

  logic                ch_q;
  logic                val_q;
  logic                sop_q;
  logic                eop_q;
  logic [ST_WIDTH-1:0] dat_q;
  logic [ST_WIDTH-2:0] hp_seq_q;
  logic [ST_WIDTH-2:0] lp_seq_q;

  logic                load;
  logic                gnt_en;
  logic                gnt_ch;
  logic                in_val;
  logic                in_eop;
  logic [ST_WIDTH-1:0] in_dat;
  logic [ST_WIDTH-2:0] seq_sel;
  logic [ST_WIDTH-1:0] hdr;
  logic                hp_rdy;
  logic                lp_rdy;
  logic                unused_sop;

  assign unused_sop = hp_i.sop ^ lp_i.sop;

  assign load   = !val_q || ll_o.rdy;
  assign gnt_en = (state_q == LL_MUX_IDLE) && ll_linkup
               && load && (hp_i.val || lp_i.val);

  assign in_val = (ch_q == LL_CH_HP) ? hp_i.val : lp_i.val;
  assign in_eop = (ch_q == LL_CH_HP) ? hp_i.eop : lp_i.eop;
  assign in_dat = (ch_q == LL_CH_HP) ? hp_i.dat : lp_i.dat;

  assign seq_sel = (gnt_ch == LL_CH_HP) ? hp_seq_q : lp_seq_q;
  assign hdr = ST_WIDTH'(liic_ll_hdr(gnt_ch, (LL_HDR_MAX-1)'(seq_sel)));

  liic_ll_tx_arb #(
    .HP_BURST (HP_BURST)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .linkup_i (ll_linkup),
    .hp_val_i (hp_i.val),
    .lp_val_i (lp_i.val),
    .gnt_en_i (gnt_en),
    .gnt_ch_o (gnt_ch)
  );

  // Link down in IDLE sinks both inputs; DROP sinks the aborted one.
  always_comb begin
    hp_rdy = 1'b0;
    lp_rdy = 1'b0;
    unique case (state_q)
      LL_MUX_IDLE: begin
        hp_rdy = !ll_linkup;
        lp_rdy = !ll_linkup;
      end
      LL_MUX_DATA: begin
        hp_rdy = ll_linkup && load && (ch_q == LL_CH_HP);
        lp_rdy = ll_linkup && load && (ch_q == LL_CH_LP);
      end
      LL_MUX_DROP: begin
        hp_rdy = (ch_q == LL_CH_HP);
        lp_rdy = (ch_q == LL_CH_LP);
      end
      default: ;
    endcase
  end

  assign hp_i.rdy = hp_rdy && rst;
  assign lp_i.rdy = lp_rdy && rst;

  assign ll_o.val = val_q;
  assign ll_o.sop = sop_q;
  assign ll_o.eop = eop_q;
  assign ll_o.dat = dat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LL_MUX_IDLE;
      ch_q     <= LL_CH_LP;
      val_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      dat_q    <= '0;
      hp_seq_q <= '0;
      lp_seq_q <= '0;
    end else begin
      if (!ll_linkup) begin
        hp_seq_q <= '0;
        lp_seq_q <= '0;
      end
      unique case (state_q)
        LL_MUX_IDLE: begin
          if (!ll_linkup) begin
            val_q <= 1'b0;
          end else if (gnt_en) begin
            val_q   <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            dat_q   <= hdr;
            ch_q    <= gnt_ch;
            state_q <= LL_MUX_DATA;
            if (gnt_ch == LL_CH_HP) hp_seq_q <= hp_seq_q + 1'b1;
            else                    lp_seq_q <= lp_seq_q + 1'b1;
          end else if (load) begin
            val_q <= 1'b0;
          end
        end
        LL_MUX_DATA: begin
          if (!ll_linkup) begin
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            dat_q   <= '0;
            state_q <= LL_MUX_DROP;
          end else if (load) begin
            val_q <= in_val;
            if (in_val) begin
              sop_q <= 1'b0;
              eop_q <= in_eop;
              dat_q <= in_dat;
              if (in_eop) state_q <= LL_MUX_IDLE;
            end
          end
        end
        LL_MUX_DROP: begin
          if (in_val && in_eop) state_q <= LL_MUX_IDLE;
        end
        default: state_q <= LL_MUX_IDLE;
      endcase
    end
  end

`ifdef LIIC_LL_TX_MUX_STATS_EN
  logic [31:0] hp_cnt_q;
  logic [31:0] lp_cnt_q;
  logic [15:0] drop_q;
  logic [1:0]  drop_inc;
  logic        eop_xfer;

  assign eop_xfer = val_q && ll_o.rdy && eop_q;

  // Aborts count on entry to DROP; idle discards count per eop word.
  always_comb begin
    drop_inc = '0;
    if (!ll_linkup) begin
      unique case (state_q)
        LL_MUX_DATA: drop_inc = 2'd1;
        LL_MUX_IDLE: drop_inc = {1'b0, hp_i.val && hp_i.eop}
                              + {1'b0, lp_i.val && lp_i.eop};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_cnt_q <= '0;
      lp_cnt_q <= '0;
      drop_q   <= '0;
    end else begin
      if (!ll_linkup) begin
        hp_cnt_q <= '0;
        lp_cnt_q <= '0;
      end else if (eop_xfer) begin
        if (ch_q == LL_CH_HP && !(&hp_cnt_q)) hp_cnt_q <= hp_cnt_q + 1'b1;
        if (ch_q == LL_CH_LP && !(&lp_cnt_q)) lp_cnt_q <= lp_cnt_q + 1'b1;
      end
      if (drop_inc != 2'd0)
        drop_q <= (drop_q > 16'hFFFD) ? 16'hFFFF : drop_q + 16'(drop_inc);
      else if (!ll_linkup)
        drop_q <= '0;
    end
  end

  assign hp_pkt_cnt = hp_cnt_q;
  assign lp_pkt_cnt = lp_cnt_q;
  assign drop_cnt   = drop_q;
`endif

endmodule

// File: tb/tb_liic_ll_tx_mux.sv
// Bench for liic_ll_tx_mux: directed scenarios plus random traffic
// against a packet-level model of tagging, arbitration and sequencing.
module tb_liic_ll_tx_mux;
  localparam int W = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst;
  logic linkup;

  always #5 clk = ~clk;

  liic_ll_tx_mux_if #(.W(W)) hp_if ();
  liic_ll_tx_mux_if #(.W(W)) lp_if ();
  liic_ll_tx_mux_if #(.W(W)) ll_if ();

`ifdef LIIC_LL_TX_MUX_STATS_EN
  logic [31:0] hp_cnt;
  logic [31:0] lp_cnt;
  logic [15:0] drp_cnt;
`endif

  liic_ll_tx_mux #(
    .ST_WIDTH (W),
    .HP_BURST (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ll_linkup (linkup),
    .hp_i      (hp_if),
    .lp_i      (lp_if),
    .ll_o      (ll_if)
`ifdef LIIC_LL_TX_MUX_STATS_EN
    ,
    .hp_pkt_cnt (hp_cnt),
    .lp_pkt_cnt (lp_cnt),
    .drop_cnt   (drp_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // words are {sop, eop, dat}
  logic [9:0] hp_src[$];
  logic [9:0] lp_src[$];
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];
  int         hp_len[$];
  int         lp_len[$];

  int         rdy_mode = 0;
  bit         hold_en = 0;
  bit         prev_stall = 0;
  logic [9:0] prev_w;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    hp_if.val = hp_src.size() > 0;
    {hp_if.sop, hp_if.eop, hp_if.dat} = '0;
    if (hp_src.size() > 0) {hp_if.sop, hp_if.eop, hp_if.dat} = hp_src[0];
    lp_if.val = lp_src.size() > 0;
    {lp_if.sop, lp_if.eop, lp_if.dat} = '0;
    if (lp_src.size() > 0) {lp_if.sop, lp_if.eop, lp_if.dat} = lp_src[0];
  endtask

  task automatic step();
    bit hacc, lacc;
    @(negedge clk);
    hacc = hp_if.val && hp_if.rdy;
    lacc = lp_if.val && lp_if.rdy;
    if (hold_en && prev_stall)
      chk("hold", {ll_if.val, ll_if.sop, ll_if.eop, ll_if.dat}, {1'b1, prev_w});
    prev_stall = ll_if.val && !ll_if.rdy;
    prev_w = {ll_if.sop, ll_if.eop, ll_if.dat};
    if (ll_if.val && ll_if.rdy) out_q.push_back({ll_if.sop, ll_if.eop, ll_if.dat});
    @(posedge clk);
    #1;
    if (hacc) void'(hp_src.pop_front());
    if (lacc) void'(lp_src.pop_front());
    unique case (rdy_mode)
      0: ll_if.rdy = 1'b1;
      1: ll_if.rdy = ~ll_if.rdy;
      default: ll_if.rdy = 1'($urandom_range(0, 1));
    endcase
    drive();
  endtask

  task automatic add_pkt(input bit hp, input int len);
    logic [9:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == 0), (i == len - 1), 8'($urandom)};
      if (hp) hp_src.push_back(w);
      else    lp_src.push_back(w);
    end
    if (hp) hp_len.push_back(len);
    else    lp_len.push_back(len);
  endtask

  // Packet-level model: both streams offered back to back from a fresh link.
  task automatic build_exp();
    logic [9:0] hq[$];
    logic [9:0] lq[$];
    int run, n, hs, ls, hdr;
    bit pick;
    hq = hp_src;
    lq = lp_src;
    run = 0;
    hs = 0;
    ls = 0;
    while (hp_len.size() > 0 || lp_len.size() > 0) begin
      pick = hp_len.size() > 0 && !(lp_len.size() > 0 && run == B);
      if (pick) run = (lp_len.size() > 0) ? ((run < B) ? run + 1 : B) : 0;
      else      run = 0;
      if (pick) begin
        hdr = hs * 2 + 1;
        hs = (hs + 1) % (1 << (W - 1));
        n = hp_len.pop_front();
      end else begin
        hdr = ls * 2;
        ls = (ls + 1) % (1 << (W - 1));
        n = lp_len.pop_front();
      end
      exp_q.push_back({2'b10, 8'(hdr)});
      for (int k = 0; k < n; k++) begin
        logic [9:0] w;
        w = pick ? hq.pop_front() : lq.pop_front();
        exp_q.push_back({1'b0, (k == n - 1), w[7:0]});
      end
    end
  endtask

  task automatic run_until();
    int n = 0;
    while (out_q.size() < exp_q.size() && n < 4000) begin
      step();
      n++;
    end
    chk("run_timeout", 32'(n < 4000), 32'd1);
    repeat (4) step();
  endtask

  task automatic compare(input string tag);
    int m;
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s[%0d]", tag, i), out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic link_reset();
    linkup = 1'b0;
    step();
    step();
    linkup = 1'b1;
    step();
    out_q.delete();
  endtask

  initial begin
    logic [7:0] exp_h[6];
    int n;
    exp_h = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h00, 8'h09};

    rst = 1'b0;
    linkup = 1'b0;
    ll_if.rdy = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", ll_if.val, 0);
    chk("rst_sop", ll_if.sop, 0);
    chk("rst_eop", ll_if.eop, 0);
    chk("rst_dat", ll_if.dat, 0);
    chk("rst_hp_rdy", hp_if.rdy, 0);
    chk("rst_lp_rdy", lp_if.rdy, 0);
    rst = 1'b1;
    ll_if.rdy = 1'b1;
    #1;
    chk("down_hp_rdy", hp_if.rdy, 1);
    chk("down_lp_rdy", lp_if.rdy, 1);
    linkup = 1'b1;
    step();
    chk("idle_hp_rdy", hp_if.rdy, 0);

    // single 3-word HP packet, header latency
    hp_src.push_back(10'h211);
    hp_src.push_back(10'h022);
    hp_src.push_back(10'h133);
    hp_len.push_back(3);
    build_exp();
    drive();
    step();
    chk("hdr_lat_val", ll_if.val, 1);
    chk("hdr_lat_word", {ll_if.sop, ll_if.eop, ll_if.dat}, 10'h201);
    run_until();
    chk("p3_last", (out_q.size() > 3) ? out_q[3] : 10'hx, 10'h133);
    compare("p3");

    // HP burst limit with both streams busy
    link_reset();
    for (int i = 0; i < 6; i++) add_pkt(1, 1);
    for (int i = 0; i < 2; i++) add_pkt(0, 1);
    build_exp();
    drive();
    run_until();
    for (int i = 0; i < 6; i++)
      chk($sformatf("burst_hdr%0d", i),
          (out_q.size() > 2 * i) ? out_q[2 * i] : 10'hx, {2'b10, exp_h[i]});
    compare("burst");

    // toggling link ready
    link_reset();
    rdy_mode = 1;
    hold_en = 1;
    add_pkt(1, 4);
    build_exp();
    drive();
    run_until();
    compare("toggle");
    rdy_mode = 0;
    hold_en = 0;

    // link drop mid-packet
    link_reset();
    for (int i = 0; i < 6; i++)
      hp_src.push_back({(i == 0), (i == 5), 8'(8'hA0 + i)});
    drive();
    n = 0;
    while (hp_src.size() > 4 && n < 50) begin
      step();
      n++;
    end
    chk("abort_reach", hp_src.size(), 4);
    linkup = 1'b0;
    step();
    chk("abort_val", ll_if.val, 0);
    n = 0;
    while (hp_src.size() > 0 && n < 20) begin
      chk("drop_rdy", hp_if.rdy, 1);
      step();
      n++;
    end
    chk("drop_empty", hp_src.size(), 0);
    chk("drop_quiet", ll_if.val, 0);
    chk("abort_len", out_q.size(), 3);
    chk("abort_w0", (out_q.size() > 0) ? out_q[0] : 10'hx, 10'h201);
    chk("abort_w2", (out_q.size() > 2) ? out_q[2] : 10'hx, 10'h0A1);
    linkup = 1'b1;
    step();
    out_q.delete();
    add_pkt(1, 1);
    build_exp();
    drive();
    run_until();
    chk("relink_hdr", (out_q.size() > 0) ? out_q[0] : 10'hx, 10'h201);
    compare("relink");

    // sequence wrap on LP
    link_reset();
    for (int i = 0; i < 129; i++) add_pkt(0, 1);
    build_exp();
    drive();
    run_until();
    chk("wrap_hdr", (out_q.size() > 256) ? out_q[256] : 10'hx, 10'h200);
    compare("wrap");

    // random mix with random backpressure
    link_reset();
    rdy_mode = 2;
    hold_en = 1;
    for (int i = 0; i < 8; i++) add_pkt(1, $urandom_range(1, 5));
    for (int i = 0; i < 6; i++) add_pkt(0, $urandom_range(1, 5));
    build_exp();
    drive();
    run_until();
    compare("rand");
    rdy_mode = 0;
    hold_en = 0;

`ifdef LIIC_LL_TX_MUX_STATS_EN
    link_reset();
    for (int i = 0; i < 3; i++) add_pkt(1, 1);
    for (int i = 0; i < 2; i++) add_pkt(0, 1);
    build_exp();
    drive();
    run_until();
    compare("stats_traffic");
    chk("hp_pkt_cnt", hp_cnt, 3);
    chk("lp_pkt_cnt", lp_cnt, 2);
    add_pkt(1, 3);
    hp_len.delete();
    drive();
    n = 0;
    while (hp_src.size() > 2 && n < 50) begin
      step();
      n++;
    end
    linkup = 1'b0;
    step();
    chk("drop_cnt", drp_cnt, 1);
    n = 0;
    while (hp_src.size() > 0 && n < 20) begin
      step();
      n++;
    end
    link_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
